mux16_arbiter: RTL and testbench
================================

# mux16_arbiter

Round-robin arbiter that shares one 16:1 selection datapath among 16 requesters. It registers a single winner per transaction and drives the 4-bit select of the downstream 16-input multiplexer. It holds the grant until the consumer signals completion, then rotates priority. It sits between the CPU's shared-resource requesters (load/store ports, debug, interrupt sources) and the mux whose select it owns.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles a grant may stay in BUSY without `done`. Only used when the timeout feature is compiled in. Minimum value 2.
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  16  request lines; bit i = requester i. Level-sensitive.
- done  in  1  one-cycle completion pulse from the consumer of the selected path.
- grant  out  16  one-hot grant, registered. All zero when `valid`=0.
- sel  out  4  binary index of the granted requester; drives the mux select. Registered.
- valid  out  1  high while a grant is active (state BUSY).
- timeout  out  1  one-cycle pulse when a grant is forcibly released. Tied 0 when the feature is compiled out.

## Operation
- States: IDLE and BUSY. Reset values:
  - state=IDLE, grant=0, sel=0, valid=0, timeout=0.
  - last-winner pointer ptr=4'hF, so requester 0 has top priority after reset.
  - watchdog counter=0.
- Winner search: scan indices ptr+1, ptr+2, … wrapping mod 16, and take the first index with req set. This guarantees the last winner has the lowest priority.
- IDLE:
  - If req≠0, register the winner into sel and grant, set valid=1 and go to BUSY.
  - If req=0, stay in IDLE.
- BUSY: outputs hold constant. The grant is released when any of these occurs:
  - (a) `done`=1;
  - (b) req[sel]=0, meaning the requester abandoned the transaction;
  - (c) a timeout fires.
- On release:
  - ptr←sel.
  - If another request is pending (req with bit sel masked off is nonzero), register the new winner in the same edge and stay in BUSY. This gives back-to-back grants with no idle cycle.
  - Otherwise clear grant, set valid=0 and go to IDLE.
- Simultaneous events:
  - `done` together with req[sel] dropping is treated as a single release.
  - `done` together with a timeout is treated as a normal `done`: timeout stays 0.
- `done` while in IDLE is ignored.
- A requester whose req stays high after release is excluded only from the immediate re-grant. It competes again in the next arbitration.
- Reset asserted mid-transaction returns all state to reset values immediately, without waiting for a clock edge.

## Timing
- req rises before edge N in IDLE: grant, sel and valid are visible after edge N (1-cycle latency).
- `done` sampled at edge M:
  - the next grant is visible after edge M if a request is pending;
  - otherwise valid=0 after edge M.
- Combinational path: req → winner logic → grant/sel registers only. There is no combinational path from any input to any output.
- The consumer must not assert `done` in the same cycle a grant first appears unless it completes in one cycle. One-cycle completion is legal.

## Configuration
- MUX16_ARB_TIMEOUT_EN defined:
  - The watchdog counter clears on every entry to BUSY and on every new grant.
  - It increments each BUSY cycle.
  - When it reaches TIMEOUT_CYCLES−1 with no `done`, the next edge releases the grant per the rules above, and `timeout` pulses high for exactly that one cycle.
  - Counter width is $clog2(TIMEOUT_CYCLES).
- Not defined: no counter is built, `timeout` is tied to 0, and a grant lasts until `done` or until req[sel] drops.

## Structure
- Shared package `arb_pkg` holds:
  - the NUM_REQ=16 and SEL_W=4 constants;
  - the state enum (IDLE, BUSY);
  - a function converting a 4-bit index to a one-hot vector.
- Sub-module `rr_pick16` is purely combinational:
  - inputs: req[15:0], ptr[3:0];
  - outputs: found, idx[3:0];
  - method: rotate right by ptr+1, find-first-set, add ptr+1 mod 16.
- The top level contains the state register, ptr, the output registers and the optional watchdog.

## Test plan
- Reset then req=16'h0001 → after one edge: grant=16'h0001, sel=0, valid=1. Then `done` → valid=0 and ptr=0.
- req=16'h8101 held, `done` pulsed each grant → sel sequence 0, 8, 15, 0 with no idle cycle between grants.
- In BUSY with sel=3, drop req[3] while req[5]=1 → next edge: sel=5, valid=1, timeout=0.
- `done` asserted in IDLE with req=0 → no state change, valid remains 0.
- Feature on, TIMEOUT_CYCLES=4, req=16'h0010 held, no `done` → timeout=1 on the 4th BUSY cycle's release edge. The same requester is re-granted on the following arbitration, and timeout returns to 0.
- Assert reset while BUSY with sel=7 → grant=0, sel=0, valid=0 asynchronously. After release with req=16'h0081 → sel=0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the 16-way arbiter.
package arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int SEL_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick16.sv
// Combinational round-robin picker: first set bit of req scanning from ptr+1 upward, wrapping mod 16.
module rr_pick16
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0]   w_start;
  logic [NUM_REQ-1:0] w_rot;
  logic [SEL_W-1:0]   w_off;
  logic               w_found;

  // Rotate so that index ptr+1 lands on bit 0; lowest set bit is then the winner.
  assign w_start = ptr + SEL_W'(1);
  assign w_rot   = (req >> w_start) | (req << (5'd16 - {1'b0, w_start}));

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) begin
        w_found = 1'b1;
        w_off   = SEL_W'(i);
      end
    end
  end

  assign found = w_found;
  assign idx   = w_off + w_start;

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter owning the select of a 16:1 mux; holds each grant until done, abandon or watchdog.
// Optional watchdog compiled in with `define MUX16_ARB_TIMEOUT_EN.
module mux16_arbiter
  import arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output logic [SEL_W-1:0]   sel,
  output logic               valid,
  output logic               timeout
);

  state_t             r_state;
  logic [SEL_W-1:0]   r_ptr;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_REQ-1:0] r_grant;
  logic               r_valid;
  logic               r_timeout;

  logic               w_busy;
  logic               w_fire;
  logic               w_release;
  logic [NUM_REQ-1:0] w_pick_req;
  logic [SEL_W-1:0]   w_pick_ptr;
  logic               w_found;
  logic [SEL_W-1:0]   w_idx;

  assign w_busy    = (r_state == BUSY);
  assign w_release = w_busy && (done || !req[r_sel] || w_fire);

  // While busy the only arbitration that matters is the release re-grant, which
  // excludes the current holder and treats it as the newest winner.
  assign w_pick_req = w_busy ? (req & ~r_grant) : req;
  assign w_pick_ptr = w_busy ? r_sel : r_ptr;

  rr_pick16 u_pick (
    .req   (w_pick_req),
    .ptr   (w_pick_ptr),
    .found (w_found),
    .idx   (w_idx)
  );

`ifdef MUX16_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;

  assign w_fire = w_busy && (r_cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (!w_busy || w_release) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
`else
  // Without the watchdog a grant never expires; the parameter only matters when it is built.
  assign w_fire = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_ptr     <= '1;
      r_sel     <= '0;
      r_grant   <= '0;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= BUSY;
            r_sel   <= w_idx;
            r_grant <= idx2onehot(w_idx);
            r_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (w_release) begin
            r_ptr     <= r_sel;
            r_timeout <= w_fire && !done;
            if (w_found) begin
              r_sel   <= w_idx;
              r_grant <= idx2onehot(w_idx);
            end else begin
              r_state <= IDLE;
              r_grant <= '0;
              r_valid <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign grant   = r_grant;
  assign sel     = r_sel;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_mux16_arbiter.sv
// Directed self-checking bench for mux16_arbiter; watchdog scenario follows MUX16_ARB_TIMEOUT_EN.
module tb_mux16_arbiter;

  logic        clk;
  logic        reset;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  sel;
  logic        valid;
  logic        timeout;

  int n_pass  = 0;
  int n_total = 0;

  mux16_arbiter #(.TIMEOUT_CYCLES(4)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .sel     (sel),
    .valid   (valid),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    req   = 16'h0;
    done  = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 16'h0;
    done  = 1'b0;
    tick();
    tick();
    n_total++;
    if ({grant, sel, valid, timeout} !== 22'h0)
      $display("FAIL reset_outputs: grant=%h sel=%0d valid=%b timeout=%b, expected all zero", grant, sel, valid, timeout);
    else n_pass++;
    reset = 1'b0;
    tick();
    n_total++;
    if (valid !== 1'b0) $display("FAIL reset_idle_no_req: valid=%b expected 0", valid);
    else n_pass++;
  endtask

  task automatic test_single();
    req = 16'h0001;
    tick();
    n_total++;
    if (grant !== 16'h0001 || sel !== 4'd0 || valid !== 1'b1)
      $display("FAIL single_grant: grant=%h sel=%0d valid=%b expected 0001/0/1", grant, sel, valid);
    else n_pass++;
    done = 1'b1;
    tick();
    done = 1'b0;
    req  = 16'h0;
    n_total++;
    if (valid !== 1'b0 || grant !== 16'h0)
      $display("FAIL single_done_release: valid=%b grant=%h expected 0/0000", valid, grant);
    else n_pass++;
    // ptr is now 0, so requester 1 outranks requester 0.
    req = 16'h0003;
    tick();
    n_total++;
    if (sel !== 4'd1 || grant !== 16'h0002)
      $display("FAIL ptr_after_done: sel=%0d grant=%h expected 1/0002", sel, grant);
    else n_pass++;
    req = 16'h0;
    tick();
    n_total++;
    if (valid !== 1'b0) $display("FAIL drop_to_idle: valid=%b expected 0", valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_sel [3] = '{4'd8, 4'd15, 4'd0};
    pulse_reset();
    req = 16'h8101;
    tick();
    n_total++;
    if (sel !== 4'd0 || valid !== 1'b1)
      $display("FAIL b2b_first: sel=%0d valid=%b expected 0/1", sel, valid);
    else n_pass++;
    done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_total++;
      if (sel !== exp_sel[i] || valid !== 1'b1 || grant !== (16'h1 << exp_sel[i]))
        $display("FAIL b2b_step%0d: sel=%0d valid=%b grant=%h expected sel=%0d valid=1", i, sel, valid, grant, exp_sel[i]);
      else n_pass++;
    end
    done = 1'b0;
    req  = 16'h0;
    tick();
    n_total++;
    if (valid !== 1'b0) $display("FAIL b2b_end_idle: valid=%b expected 0", valid);
    else n_pass++;
  endtask

  task automatic test_abandon();
    pulse_reset();
    req = 16'h0008;
    tick();
    n_total++;
    if (sel !== 4'd3) $display("FAIL abandon_setup: sel=%0d expected 3", sel);
    else n_pass++;
    req = 16'h0020;
    tick();
    n_total++;
    if (sel !== 4'd5 || valid !== 1'b1 || timeout !== 1'b0 || grant !== 16'h0020)
      $display("FAIL abandon_regrant: sel=%0d valid=%b timeout=%b grant=%h expected 5/1/0/0020", sel, valid, timeout, grant);
    else n_pass++;
    req = 16'h0;
    tick();
  endtask

  task automatic test_done_idle();
    req  = 16'h0;
    done = 1'b1;
    tick();
    tick();
    done = 1'b0;
    n_total++;
    if (valid !== 1'b0 || grant !== 16'h0 || timeout !== 1'b0)
      $display("FAIL done_in_idle: valid=%b grant=%h timeout=%b expected 0/0000/0", valid, grant, timeout);
    else n_pass++;
  endtask

  task automatic test_timeout();
    pulse_reset();
    req = 16'h0010;
    tick();
`ifdef MUX16_ARB_TIMEOUT_EN
    for (int c = 2; c <= 4; c++) begin
      tick();
      n_total++;
      if (timeout !== 1'b0 || valid !== 1'b1)
        $display("FAIL to_busy_cycle%0d: timeout=%b valid=%b expected 0/1", c, timeout, valid);
      else n_pass++;
    end
    tick();
    n_total++;
    if (timeout !== 1'b1 || valid !== 1'b0 || grant !== 16'h0)
      $display("FAIL to_fire: timeout=%b valid=%b grant=%h expected 1/0/0000", timeout, valid, grant);
    else n_pass++;
    tick();
    n_total++;
    if (timeout !== 1'b0 || valid !== 1'b1 || sel !== 4'd4)
      $display("FAIL to_regrant: timeout=%b valid=%b sel=%0d expected 0/1/4", timeout, valid, sel);
    else n_pass++;
`else
    for (int c = 0; c < 12; c++) begin
      tick();
      n_total++;
      if (timeout !== 1'b0 || valid !== 1'b1 || sel !== 4'd4)
        $display("FAIL no_to_hold%0d: timeout=%b valid=%b sel=%0d expected 0/1/4", c, timeout, valid, sel);
      else n_pass++;
    end
`endif
    req = 16'h0;
    tick();
  endtask

  task automatic test_async_reset();
    pulse_reset();
    req = 16'h0080;
    tick();
    n_total++;
    if (sel !== 4'd7 || valid !== 1'b1)
      $display("FAIL areset_setup: sel=%0d valid=%b expected 7/1", sel, valid);
    else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_total++;
    if (grant !== 16'h0 || sel !== 4'd0 || valid !== 1'b0)
      $display("FAIL areset_async: grant=%h sel=%0d valid=%b expected 0000/0/0", grant, sel, valid);
    else n_pass++;
    req = 16'h0081;
    tick();
    reset = 1'b0;
    tick();
    n_total++;
    if (sel !== 4'd0 || grant !== 16'h0001 || valid !== 1'b1)
      $display("FAIL areset_regrant: sel=%0d grant=%h valid=%b expected 0/0001/1", sel, grant, valid);
    else n_pass++;
    req = 16'h0;
    tick();
  endtask

  initial begin
    reset = 1'b1;
    req   = 16'h0;
    done  = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abandon();
    test_done_idle();
    test_timeout();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks so far %0d/%0d", n_pass, n_total);
    $fatal(1);
  end

endmodule
